ms_jk_bank: RTL and testbench

MS_JK_BANK -- requirements
Module: ms_jk_bank

---
 rtl/ms_jk_pkg.sv | 20 ++
 rtl/jk_cell.sv | 26 ++
 rtl/ms_jk_bank.sv | 100 ++++++++++
 tb/tb_ms_jk_bank.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/ms_jk_pkg.sv
// ms_jk_pkg: shared encodings for the master/slave JK bank.
//   mode_e : operation select driven on the bank's mode port.
//   jk_e   : {j,k} input pair as seen by a single JK cell.
package ms_jk_pkg;

    typedef enum logic [1:0] {
        MODE_JK = 2'b00,   // per-bit JK from j/k ports
        MODE_UP = 2'b01,   // synchronous up-count
        MODE_DN = 2'b10,   // synchronous down-count
        MODE_LD = 2'b11    // parallel load from load_val
    } mode_e;

    typedef enum logic [1:0] {
        JK_HOLD   = 2'b00,
        JK_RESET  = 2'b01,
        JK_SET    = 2'b10,
        JK_TOGGLE = 2'b11
    } jk_e;

endpackage

// File: rtl/jk_cell.sv
// jk_cell: combinational next-state of one JK bit.
//   q : current bit value
//   j : J input
//   k : K input
//   d : value the bit takes when its register is enabled
module jk_cell
    import ms_jk_pkg::*;
(
    input  logic q,
    input  logic j,
    input  logic k,
    output logic d
);

    always_comb begin
        d = q;
        case (jk_e'({j, k}))
            JK_HOLD:   d = q;
            JK_RESET:  d = 1'b0;
            JK_SET:    d = 1'b1;
            JK_TOGGLE: d = ~q;
            default:   d = q;
        endcase
    end

endmodule

// File: rtl/ms_jk_bank.sv
// ms_jk_bank: WIDTH-bit master/slave JK register bank.
//   clk, rst_n   : clock (posedge) and async active-low reset
//   mode         : 00 JK, 01 count up, 10 count down, 11 load
//   j, k         : per-bit JK inputs (JK mode only)
//   load_val     : parallel value (load mode only)
//   capture      : update master from its next-state this cycle
//   transfer     : copy the pre-edge master into the slave
//   q, qn        : slave state and its complement
//   master_q     : master state
//   pending      : master captured but not yet transferred
//   tc           : terminal count of the slave for the current count mode
module ms_jk_bank
    import ms_jk_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] load_val,
    input  logic             capture,
    input  logic             transfer,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] master_q,
    output logic             pending,
    output logic             tc
);

    logic [WIDTH-1:0] master;
    logic [WIDTH-1:0] slave;
    logic [WIDTH-1:0] up_en;
    logic [WIDTH-1:0] dn_en;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] master_nxt;

    // Counter toggle enables: a bit toggles when every lower bit is 1 (up)
    // or every lower bit is 0 (down); bit 0 always toggles.
    always_comb begin
        logic up_acc;
        logic dn_acc;
        up_en  = '0;
        dn_en  = '0;
        up_acc = 1'b1;
        dn_acc = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            up_en[i] = up_acc;
            dn_en[i] = dn_acc;
            up_acc   = up_acc & master[i];
            dn_acc   = dn_acc & ~master[i];
        end
    end

    // Every mode is expressed as J/K pairs so the cells do all the work;
    // load maps each bit to set (1) or reset (0).
    always_comb begin
        cell_j = '0;
        cell_k = '0;
        case (mode_e'(mode))
            MODE_JK: begin cell_j = j;        cell_k = k;         end
            MODE_UP: begin cell_j = up_en;    cell_k = up_en;     end
            MODE_DN: begin cell_j = dn_en;    cell_k = dn_en;     end
            MODE_LD: begin cell_j = load_val; cell_k = ~load_val; end
            default: begin cell_j = '0;       cell_k = '0;        end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .q (master[i]),
            .j (cell_j[i]),
            .k (cell_k[i]),
            .d (master_nxt[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            master  <= '0;
            slave   <= '0;
            pending <= 1'b0;
        end else begin
            if (capture)  master <= master_nxt;
            // slave sees the pre-edge master, giving the two-stage pipeline
            if (transfer) slave  <= master;
            if (capture)       pending <= 1'b1;
            else if (transfer) pending <= 1'b0;
        end
    end

    assign master_q = master;
    assign q        = slave;
    assign qn       = ~slave;
    assign tc       = ((mode_e'(mode) == MODE_UP) && (&slave)) ||
                      ((mode_e'(mode) == MODE_DN) && (~|slave));

endmodule

// File: tb/tb_ms_jk_bank.sv
module tb_ms_jk_bank;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [1:0]   mode = 2'b00;
    logic [W-1:0] j = '0, k = '0, load_val = '0;
    logic         capture = 1'b0, transfer = 1'b0;
    logic [W-1:0] q, qn, master_q;
    logic         pending, tc;

    int n_cmp = 0;
    int n_err = 0;

    // reference state
    logic [W-1:0] m_m, m_q;
    logic         m_p;

    ms_jk_bank #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .j(j), .k(k),
        .load_val(load_val), .capture(capture), .transfer(transfer),
        .q(q), .qn(qn), .master_q(master_q), .pending(pending), .tc(tc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tc();
        return (mode == 2'b01 && m_q == 4'hF) || (mode == 2'b10 && m_q == 4'h0);
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".master"},  32'(master_q), 32'(m_m));
        chk({tag, ".q"},       32'(q),        32'(m_q));
        chk({tag, ".qn"},      32'(qn),       32'(4'hF - m_q));
        chk({tag, ".pending"}, 32'(pending),  32'(m_p));
        chk({tag, ".tc"},      32'(tc),       32'(exp_tc()));
    endtask

    // next master value from the rules, using plain arithmetic
    function automatic logic [W-1:0] next_master(input logic [1:0] md, input logic [W-1:0] m,
                                                 input logic [W-1:0] jj, input logic [W-1:0] kk,
                                                 input logic [W-1:0] lv);
        logic [W-1:0] r;
        case (md)
            2'b00: begin
                r = m;
                for (int b = 0; b < W; b++) begin
                    if (jj[b] && kk[b]) r[b] = ~m[b];
                    else if (jj[b])     r[b] = 1'b1;
                    else if (kk[b])     r[b] = 1'b0;
                end
            end
            2'b01:   r = W'((int'(m) + 1) % 16);
            2'b10:   r = W'((int'(m) + 15) % 16);
            default: r = lv;
        endcase
        return r;
    endfunction

    // inputs applied after the negedge check, model advanced at posedge
    task automatic step(input string tag, input logic [1:0] md, input logic [W-1:0] jj,
                        input logic [W-1:0] kk, input logic [W-1:0] lv,
                        input logic c, input logic t);
        logic [W-1:0] nm;
        mode = md; j = jj; k = kk; load_val = lv; capture = c; transfer = t;
        @(posedge clk);
        nm = c ? next_master(md, m_m, jj, kk, lv) : m_m;
        if (t) m_q = m_m;
        m_m = nm;
        if (c) m_p = 1'b1;
        else if (t) m_p = 1'b0;
        @(negedge clk);
        check_all(tag);
    endtask

    // async reset asserted between edges, checked before any edge arrives
    task automatic do_reset(input string tag);
        #2 rst_n = 1'b0;
        m_m = '0; m_q = '0; m_p = 1'b0;
        #1 check_all(tag);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        m_m = '0; m_q = '0; m_p = 1'b0;
        #3 check_all("por");
        @(negedge clk);
        rst_n = 1'b1;

        // JK set/clear pattern, then transfer
        step("jk_cap", 2'b00, 4'b1010, 4'b0101, 4'h0, 1, 0);
        chk("jk_cap.master_const", 32'(master_q), 32'h A);
        step("jk_xfer", 2'b00, 4'b0000, 4'b0000, 4'h0, 0, 1);
        chk("jk_xfer.qn_const", 32'(qn), 32'h5);

        // up count through wrap with the slave one cycle behind
        do_reset("rst_up");
        for (int i = 0; i < 17; i++) step("up", 2'b01, 4'h0, 4'h0, 4'h0, 1, 1);

        // down count with no transfer, tc on q==0
        do_reset("rst_dn");
        step("dn0", 2'b10, 4'hF, 4'hF, 4'hF, 1, 0);
        chk("dn0.wrap", 32'(master_q), 32'hF);
        for (int i = 0; i < 4; i++) step("dn", 2'b10, 4'hF, 4'h0, 4'h5, 1, 0);
        chk("dn.master_const", 32'(master_q), 32'hB);
        chk("dn.tc_const", 32'(tc), 32'h1);

        // load with simultaneous transfer
        step("ld_ct", 2'b11, 4'hF, 4'hF, 4'b0110, 1, 1);

        // mode change alone does nothing
        step("mode_only", 2'b01, 4'hF, 4'hF, 4'hF, 0, 0);

        // toggle all, then hold
        step("ld3", 2'b11, 4'h0, 4'h0, 4'b0011, 1, 0);
        step("jk_tog", 2'b00, 4'hF, 4'hF, 4'h0, 1, 0);
        chk("jk_tog.const", 32'(master_q), 32'hC);
        step("jk_hold", 2'b00, 4'h0, 4'h0, 4'hF, 1, 0);

        // reset with a pending capture
        step("ld9", 2'b11, 4'h0, 4'h0, 4'b1001, 1, 0);
        do_reset("rst_pend");
        step("post_rst", 2'b01, 4'h0, 4'h0, 4'h0, 1, 0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) do_reset("rnd_rst");
            else step("rnd", 2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                      1'($urandom), 1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
